// File: rtl/key_filter.sv
// key_filter: synchronizes and debounces an active-low key line, producing a
// clean level plus one-cycle press/release events.
module key_filter #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state,
    output logic key_flag,
    output logic key_press,
    output logic key_release
);
    typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} state_t;
    state_t           state;
    logic             s0, s1, s2;
    logic [CNT_W-1:0] cnt;
    logic             nedge, pedge, done;
    assign nedge = s2 & ~s1;
    assign pedge = ~s2 & s1;
    assign done  = cnt == CNT_W'(CNT_MAX - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) {s2, s1, s0} <= 3'b111;
        else     {s2, s1, s0} <= {s1, s0, key_in};
    // An opposing edge is tested before done so a late bounce always aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_state   <= 1'b1;
            key_flag    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_flag    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: if (nedge) state <= FILT_DN;
                FILT_DN:
                    if (pedge) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (done) begin
                        state     <= DOWN;
                        cnt       <= '0;
                        key_state <= 1'b0;
                        key_flag  <= 1'b1;
                        key_press <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                DOWN: if (pedge) state <= FILT_UP;
                FILT_UP:
                    if (nedge) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (done) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_state   <= 1'b1;
                        key_flag    <= 1'b1;
                        key_release <= 1'b1;
                    end else cnt <= cnt + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed vector table plus hand sequences for key_filter,
// with a second, scaled-window instance driven by a bouncing key.
module tb_key_filter;
    logic clk = 1'b0, rst = 1'b1, key = 1'b1, key_fast = 1'b1;
    logic state, flag, press, release_p;
    logic f_state, f_flag, f_press, f_release;
    int checks = 0, errors = 0;
    int np = 0, nr = 0, fnp = 0, fnr = 0;
    int p0, r0;

    typedef struct {
        logic key;
        int   cycles;
        logic state;
        int   np;
        int   nr;
    } vec_t;
    vec_t vt[$];

    always #10 clk = ~clk;

    key_filter #(.CNT_MAX(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .key_in(key), .key_state(state),
        .key_flag(flag), .key_press(press), .key_release(release_p)
    );

    key_filter #(.CNT_MAX(500), .CNT_W(10)) u_fast (
        .clk(clk), .rst(rst), .key_in(key_fast), .key_state(f_state),
        .key_flag(f_flag), .key_press(f_press), .key_release(f_release)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance to the next falling edge and tally pulses.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (!rst) begin
            np  += int'(press);
            nr  += int'(release_p);
            fnp += int'(f_press);
            fnr += int'(f_release);
        end
        if (flag | press | release_p)
            check("pulse_consistency", {30'd0, flag, press & release_p}, {30'd0, press | release_p, 1'b0});
        if (f_flag | f_press | f_release)
            check("fast_pulse_consistency", {30'd0, f_flag, f_press & f_release}, {30'd0, f_press | f_release, 1'b0});
    endtask

    task automatic burst(input logic final_lvl);
        for (int i = 0; i < 30; i++) begin
            key_fast = ~key_fast;
            repeat ($urandom_range(1, 40)) tick();
        end
        key_fast = final_lvl;
    endtask

    initial begin
        // press/release boundaries: 8 low cycles abort at the done cycle, 9 accept
        vt.push_back('{1'b1, 50, 1'b1, 0, 0});
        vt.push_back('{1'b0, 20, 1'b0, 1, 0});
        vt.push_back('{1'b1, 20, 1'b1, 0, 1});
        vt.push_back('{1'b0,  5, 1'b1, 0, 0});
        vt.push_back('{1'b1,  3, 1'b1, 0, 0});
        vt.push_back('{1'b0,  4, 1'b1, 0, 0});
        vt.push_back('{1'b1, 30, 1'b1, 0, 0});
        vt.push_back('{1'b0,  8, 1'b1, 0, 0});
        vt.push_back('{1'b1, 20, 1'b1, 0, 0});
        vt.push_back('{1'b0,  9, 1'b1, 0, 0});
        vt.push_back('{1'b1,  2, 1'b0, 1, 0});
        vt.push_back('{1'b1, 20, 1'b1, 0, 1});
        vt.push_back('{1'b0, 20, 1'b0, 1, 0});
        vt.push_back('{1'b1,  8, 1'b0, 0, 0});
        vt.push_back('{1'b0, 20, 1'b0, 0, 0});
        vt.push_back('{1'b1,  9, 1'b0, 0, 0});
        vt.push_back('{1'b0,  2, 1'b1, 0, 1});
        vt.push_back('{1'b0, 20, 1'b0, 1, 0});
        vt.push_back('{1'b1, 20, 1'b1, 0, 1});
        vt.push_back('{1'b0,  3, 1'b1, 0, 0});
        vt.push_back('{1'b1,  2, 1'b1, 0, 0});
        vt.push_back('{1'b0,  4, 1'b1, 0, 0});
        vt.push_back('{1'b1,  1, 1'b1, 0, 0});
        vt.push_back('{1'b0,  2, 1'b1, 0, 0});
        vt.push_back('{1'b1,  2, 1'b1, 0, 0});
        vt.push_back('{1'b0, 20, 1'b0, 1, 0});
        vt.push_back('{1'b1,  3, 1'b0, 0, 0});
        vt.push_back('{1'b0,  2, 1'b0, 0, 0});
        vt.push_back('{1'b1,  4, 1'b0, 0, 0});
        vt.push_back('{1'b0,  1, 1'b0, 0, 0});
        vt.push_back('{1'b1,  2, 1'b0, 0, 0});
        vt.push_back('{1'b0,  2, 1'b0, 0, 0});
        vt.push_back('{1'b1, 20, 1'b1, 0, 1});

        repeat (5) tick();
        check("rst_state", {31'd0, state}, 32'd1);
        check("rst_flag", {31'd0, flag}, 32'd0);
        check("rst_press", {31'd0, press}, 32'd0);
        check("rst_release", {31'd0, release_p}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // exact latency: key changes just after edge 0, event at edge CNT_MAX+3
        key = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("press_lat_%0d", k), {31'd0, press}, {31'd0, k == 11});
            check($sformatf("state_dn_lat_%0d", k), {31'd0, state}, {31'd0, k < 11});
        end
        repeat (5) tick();
        key = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("release_lat_%0d", k), {31'd0, release_p}, {31'd0, k == 11});
            check($sformatf("state_up_lat_%0d", k), {31'd0, state}, {31'd0, k >= 11});
        end
        repeat (5) tick();

        for (int i = 0; i < vt.size(); i++) begin
            key = vt[i].key;
            p0 = np;
            r0 = nr;
            repeat (vt[i].cycles) tick();
            check($sformatf("vec%0d_state", i), {31'd0, state}, {31'd0, vt[i].state});
            check($sformatf("vec%0d_press", i), np - p0, vt[i].np);
            check($sformatf("vec%0d_release", i), nr - r0, vt[i].nr);
        end

        // reset while FILT_UP counter sits at 4
        key = 1'b0;
        repeat (20) tick();
        check("mid_down_state", {31'd0, state}, 32'd0);
        key = 1'b1;
        repeat (7) tick();
        r0 = nr;
        rst = 1'b1;
        #1;
        check("mid_rst_state", {31'd0, state}, 32'd1);
        check("mid_rst_flag", {31'd0, flag}, 32'd0);
        check("mid_rst_release", {31'd0, release_p}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (30) tick();
        check("mid_no_release", nr - r0, 0);
        check("mid_state_after", {31'd0, state}, 32'd1);

        // key held low through reset release
        key = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        p0 = np;
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("held_press_%0d", k), {31'd0, press}, {31'd0, k == 11});
        end
        check("held_press_count", np - p0, 1);
        key = 1'b1;
        repeat (20) tick();
        check("held_release_state", {31'd0, state}, 32'd1);

        // bouncing key against the long-window instance
        for (int n = 1; n <= 3; n++) begin
            burst(1'b0);
            check($sformatf("fast_burst_dn%0d", n), fnp, n - 1);
            repeat (1200) tick();
            check($sformatf("fast_press%0d", n), fnp, n);
            check($sformatf("fast_state_dn%0d", n), {31'd0, f_state}, 32'd0);
            burst(1'b1);
            check($sformatf("fast_burst_up%0d", n), fnr, n - 1);
            repeat (1200) tick();
            check($sformatf("fast_release%0d", n), fnr, n);
            check($sformatf("fast_state_up%0d", n), {31'd0, f_state}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
